// File: rtl/mux_read_inst_cache_if.sv
// Read-path bundle between the I-cache data array and the word mux.
// Master drives block words and offset; slave returns the selected word.
interface mux_read_inst_cache_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  read;
  logic [WORD_WIDTH-1:0] word0;
  logic [WORD_WIDTH-1:0] word1;
  logic [WORD_WIDTH-1:0] word2;
  logic [WORD_WIDTH-1:0] word3;
  logic [1:0]            offset;
  logic [WORD_WIDTH-1:0] read_inst;
  logic [WORD_WIDTH-1:0] hold_word;
  logic                  read_valid;

  modport master (
    output read,
    output word0,
    output word1,
    output word2,
    output word3,
    output offset,
    input  read_inst,
    input  hold_word,
    input  read_valid
  );

  modport slave (
    input  read,
    input  word0,
    input  word1,
    input  word2,
    input  word3,
    input  offset,
    output read_inst,
    output hold_word,
    output read_valid
  );
endinterface

// File: rtl/mux_read_inst_cache.sv
// I-cache read word select: picks one of four block words by offset,
// holds the last delivered word while read is low.
module mux_read_inst_cache #(
  parameter int WORD_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  mux_read_inst_cache_if.slave bus
);

  logic [WORD_WIDTH-1:0] sel;
  logic [WORD_WIDTH-1:0] hold_word_d;
  logic [WORD_WIDTH-1:0] hold_word_q;
  logic                  read_valid_d;
  logic                  read_valid_q;

  // Only the selected word reaches sel, so X on other words never leaks.
  always_comb begin
    sel = bus.word0;
    unique case (1'b1)
      (bus.offset == 2'd0): sel = bus.word0;
      (bus.offset == 2'd1): sel = bus.word1;
      (bus.offset == 2'd2): sel = bus.word2;
      (bus.offset == 2'd3): sel = bus.word3;
      default:              sel = bus.word0;
    endcase
  end

  always_comb begin
    hold_word_d  = hold_word_q;
    read_valid_d = bus.read;
    if (bus.read) begin
      hold_word_d = sel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_word_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      hold_word_q  <= hold_word_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign bus.read_inst  = bus.read ? sel : hold_word_q;
  assign bus.hold_word  = hold_word_q;
  assign bus.read_valid = read_valid_q;

endmodule

// File: tb/tb_mux_read_inst_cache.sv
// Bench for mux_read_inst_cache: directed plan plus random traffic
// checked against an array-indexed reference model.
module tb_mux_read_inst_cache;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic [1:0]  off;
  logic [31:0] w [4];

  int errors;
  int checks;

  logic [31:0] m_hold;
  logic        m_valid;

  mux_read_inst_cache_if #(.WORD_WIDTH(32)) bus ();

  assign bus.read   = rd;
  assign bus.offset = off;
  assign bus.word0  = w[0];
  assign bus.word1  = w[1];
  assign bus.word2  = w[2];
  assign bus.word3  = w[3];

  mux_read_inst_cache #(.WORD_WIDTH(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the model.
  task automatic chk_all(input string tag);
    logic [31:0] exp_inst;
    exp_inst = rd ? w[off] : m_hold;
    chk({tag, ".inst"}, bus.read_inst, exp_inst);
    chk({tag, ".hold"}, bus.hold_word, m_hold);
    chk({tag, ".valid"}, {31'd0, bus.read_valid}, {31'd0, m_valid});
  endtask

  // One rising edge; model samples the inputs present at that edge.
  task automatic tick();
    logic [31:0] nh;
    logic        nv;
    nh = rd ? w[off] : m_hold;
    nv = rd;
    @(posedge clk);
    if (rst_n) begin
      m_hold  = nh;
      m_valid = nv;
    end else begin
      m_hold  = '0;
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) w[i] = $urandom;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    m_hold  = '0;
    m_valid = 1'b0;

    // 1: reset held, selection still combinational
    rst_n = 1'b0;
    rd    = 1'b1;
    off   = 2'd0;
    w[0]  = 32'h11111111;
    w[1]  = 32'h22222222;
    w[2]  = 32'h33333333;
    w[3]  = 32'h44444444;
    #2;
    for (int i = 0; i < 4; i++) begin
      off = 2'(i);
      #3;
      chk("rst_sel", bus.read_inst, 32'h11111111 * (i + 1));
      chk_all("rst_sel");
    end
    tick();
    chk_all("rst_edge");

    // 2: capture and hold
    @(negedge clk);
    rst_n = 1'b1;
    rd    = 1'b1;
    off   = 2'd2;
    tick();
    chk("cap_hold", bus.hold_word, 32'h33333333);
    chk("cap_valid", {31'd0, bus.read_valid}, 32'd1);
    rd   = 1'b0;
    w[2] = 32'hDEADBEEF;
    #1;
    chk("hold_inst", bus.read_inst, 32'h33333333);
    tick();
    chk("hold_valid0", {31'd0, bus.read_valid}, 32'd0);
    chk_all("hold");

    // 3: hold ignores inputs
    for (int i = 0; i < 4; i++) begin
      off = 2'(i);
      rand_words();
      #1;
      chk("ign_inst", bus.read_inst, 32'h33333333);
      tick();
      chk("ign_hold", bus.hold_word, 32'h33333333);
      chk_all("ign");
    end

    // 4: combinational follow while reading
    rd   = 1'b1;
    off  = 2'd3;
    w[3] = 32'hCAFEF00D;
    #1;
    chk("follow_a", bus.read_inst, 32'hCAFEF00D);
    w[3] = 32'h0BADF00D;
    #1;
    chk("follow_b", bus.read_inst, 32'h0BADF00D);
    tick();
    chk("follow_cap", bus.hold_word, 32'h0BADF00D);

    // 5: async reset between edges
    rd = 1'b0;
    tick();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    m_hold  = '0;
    m_valid = 1'b0;
    #1;
    chk("arst_hold", bus.hold_word, 32'd0);
    chk("arst_inst", bus.read_inst, 32'd0);
    chk("arst_valid", {31'd0, bus.read_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd    = 1'b1;
    off   = 2'd0;
    w[0]  = 32'h5A5A1234;
    tick();
    chk("arst_cap", bus.hold_word, 32'h5A5A1234);

    // 6: back-to-back reads
    for (int i = 0; i < 4; i++) begin
      rand_words();
      off = 2'(i);
      tick();
      chk("b2b_valid", {31'd0, bus.read_valid}, 32'd1);
      chk_all("b2b");
    end

    // Read dropping right after the edge still keeps the capture
    rand_words();
    off = 2'd1;
    tick();
    rd = 1'b0;
    #1;
    chk("drop_inst", bus.read_inst, m_hold);

    // Random traffic, with read toggling between edges
    for (int n = 0; n < 200; n++) begin
      rand_words();
      off = 2'($urandom_range(0, 3));
      rd  = 1'($urandom_range(0, 1));
      #1;
      chk_all("rnd_pre");
      if ($urandom_range(0, 3) == 0) begin
        rd = ~rd;
        #1;
        chk_all("rnd_tog");
        rd = ~rd;
      end
      if ($urandom_range(0, 15) == 0) begin
        rst_n   = 1'b0;
        m_hold  = '0;
        m_valid = 1'b0;
        #1;
        chk_all("rnd_rst");
        rst_n = 1'b1;
      end
      tick();
      chk_all("rnd_post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
